// File: rtl/rf_pkg.sv
// Shared types and default sizes for the sweeping register file.
package rf_pkg;

  typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_t;

  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_DEPTH  = 32;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks a pointer over every entry, one per cycle, after reset or on request.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Next state: a clear request restarts the walk from entry 0 in either state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_i) begin
          state_d = RF_SWEEP;
          ptr_d   = '0;
        end
      end
      RF_SWEEP: begin
        if (clr_i) begin
          ptr_d = '0;
        end else if (ptr_q == LastPtr) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_SWEEP;
        ptr_d   = '0;
      end
    endcase
  end

  // State register; reset forces a fresh sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o     = (state_q == RF_SWEEP);
  // No entry is cleared on the reset edge itself.
  assign clr_en_o   = busy_o & rst_n;
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/reg_file_sweep.sv
// Parametrised register file: one write port, two async read ports, hardware clear sweep and
// per-entry written-since-clear flags. Optional macro RF_WR_BYPASS_EN forwards an accepted
// write's data to the read ports in the same cycle.
module reg_file_sweep
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned DEPTH  = RF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CLR,
  input  logic              RF_WR,
  input  logic [ADDR_W-1:0] ADRX,
  input  logic [ADDR_W-1:0] ADRY,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DX_OUT,
  output logic [DATA_W-1:0] DY_OUT,
  output logic              VLD_X,
  output logic              VLD_Y,
  output logic              BUSY,
  output logic              WR_DROP
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              vld_q [DEPTH];
  logic              wr_drop_q;

  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              x_ok, y_ok, wr_ok;

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (CLR),
    .busy_o     (busy),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  // Addresses beyond DEPTH exist when DEPTH is not a power of two.
  assign x_ok  = 32'(ADRX) < DEPTH;
  assign y_ok  = 32'(ADRY) < DEPTH;
  assign wr_ok = rst_n & ~busy & ~CLR & RF_WR & x_ok;

  // Storage: the sweep owns the array while busy, otherwise accepted writes land here.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
      vld_q[clr_addr] <= 1'b0;
    end else if (wr_ok) begin
      mem_q[ADRX] <= DIN;
      vld_q[ADRX] <= 1'b1;
    end
  end

  // One-cycle flag for a write request that was not accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= RF_WR & ~wr_ok;
    end
  end

  // Read muxes: zero while sweeping or for out-of-range addresses.
  always_comb begin
    DX_OUT = '0;
    DY_OUT = '0;
    VLD_X  = 1'b0;
    VLD_Y  = 1'b0;
    if (!busy && x_ok) begin
      DX_OUT = mem_q[ADRX];
      VLD_X  = vld_q[ADRX];
    end
    if (!busy && y_ok) begin
      DY_OUT = mem_q[ADRY];
      VLD_Y  = vld_q[ADRY];
    end
`ifdef RF_WR_BYPASS_EN
    if (wr_ok) begin
      DX_OUT = DIN;
      VLD_X  = 1'b1;
      if (ADRY == ADRX) begin
        DY_OUT = DIN;
        VLD_Y  = 1'b1;
      end
    end
`endif
  end

  assign BUSY    = busy;
  assign WR_DROP = wr_drop_q;

endmodule
